// File: rtl/jpeg_bits_packer_if.sv
// Bundles the packer's encoder-side push port and RAM-side write port.
interface jpeg_bits_packer_if #(
   parameter int IN_W   = 32,
   parameter int OUT_W  = 8,
   parameter int ADDR_W = 24,
   parameter int CNT_W  = 5
);
   // in_valid/in_eof_valid push for exactly one cycle with no ready; the encoder
   // must throttle on in_afull. out_wren qualifies out_data/out_addr for one cycle
   // and is withheld while out_almost_full is high.
   logic [IN_W-1:0]   in_bits;
   logic              in_valid;
   logic              in_eof_valid;
   logic [CNT_W-1:0]  in_eof_cnt;
   logic              in_afull;
   logic              overflow;
   logic [OUT_W-1:0]  out_data;
   logic              out_wren;
   logic [ADDR_W-1:0] out_addr;
   logic              out_almost_full;
   logic [ADDR_W-1:0] frame_size;
   logic              frame_done;

   modport master (
      output in_bits, in_valid, in_eof_valid, in_eof_cnt, out_almost_full,
      input  in_afull, overflow, out_data, out_wren, out_addr, frame_size, frame_done
   );

   modport slave (
      input  in_bits, in_valid, in_eof_valid, in_eof_cnt, out_almost_full,
      output in_afull, overflow, out_data, out_wren, out_addr, frame_size, frame_done
   );
endinterface

// File: rtl/jpeg_bits_packer.sv
// JPEG bitstream packer: FIFO-buffers MSB-first words and serialises them into
// OUT_W-bit units with a per-frame address counter and frame-size reporting.
module jpeg_bits_packer #(
   parameter int IN_W   = 32,
   parameter int OUT_W  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 24,
   parameter int CNT_W  = 5
) (
   input  logic                clock,
   input  logic                reset,
   jpeg_bits_packer_if.slave   bus,
   output logic [1:0]          dbg_state
);

   localparam int UNITS = IN_W / OUT_W;
   localparam int UW    = $clog2(UNITS + 1);
   localparam int PW    = $clog2(DEPTH);
   localparam int EW    = 1 + CNT_W + IN_W;
   localparam int OSH   = $clog2(OUT_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [EW-1:0]   mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     fill;
   logic            push_req, full, empty, do_push;
   logic [EW-1:0]   push_entry, h_entry;
   logic            h_eof;
   logic [CNT_W-1:0] h_cnt;
   logic [IN_W-1:0] h_word, h_padded, pad_mask;
   logic [CNT_W:0]  cnt_ext;
   logic [UW-1:0]   h_units;

   logic [IN_W-1:0]   shreg;
   logic [UW-1:0]     units_left;
   logic              cur_eof;
   logic [ADDR_W-1:0] addr_cnt;
   logic              issue, load, last;

   // ---------------- FIFO ----------------
   assign push_req   = bus.in_valid | bus.in_eof_valid;
   assign full       = (fill == (PW+1)'(DEPTH));
   assign empty      = (fill == '0);
   assign do_push    = push_req && !full;
   assign push_entry = {bus.in_eof_valid, bus.in_eof_cnt, bus.in_bits};
   assign bus.in_afull = (fill >= (PW+1)'(DEPTH - 2));

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill         <= '0;
         bus.overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (load)    rd_ptr <= rd_ptr + 1'b1;
         fill <= fill + (PW+1)'(do_push) - (PW+1)'(load);
         bus.overflow <= bus.overflow | (push_req && full)
                         | (bus.in_valid && bus.in_eof_valid);
      end
   end

   // Head decode: bits past the valid count of an eof word are padded with 1s.
   assign h_entry  = mem[rd_ptr];
   assign h_eof    = h_entry[EW-1];
   assign h_cnt    = h_entry[IN_W +: CNT_W];
   assign h_word   = h_entry[IN_W-1:0];
   assign pad_mask = {IN_W{1'b1}} >> h_cnt;
   assign h_padded = h_eof ? (h_word | pad_mask) : h_word;
   assign cnt_ext  = {1'b0, h_cnt} + (CNT_W+1)'(OUT_W - 1);
   assign h_units  = h_eof ? UW'(cnt_ext >> OSH) : UW'(UNITS);

   // ---------------- FSM ----------------
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   assign last = (units_left == UW'(1));

   // Nothing leaves the FIFO while the sink is blocked, so the FIFO is the
   // only buffering that backpressure has to account for.
   always_comb begin
      issue = 1'b0;
      load  = 1'b0;
      if (state == S_SHIFT && !bus.out_almost_full) issue = 1'b1;
      if (!empty && !bus.out_almost_full) begin
         if (state == S_IDLE)                  load = 1'b1;
         else if (issue && last && !cur_eof)   load = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (load) state_nxt = (h_eof && h_units == '0) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            if (issue && last) begin
               if (cur_eof)   state_nxt = S_DONE;
               else if (load) state_nxt = (h_eof && h_units == '0) ? S_DONE : S_SHIFT;
               else           state_nxt = S_IDLE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign dbg_state = state;

   // ---------------- datapath ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         shreg          <= '0;
         units_left     <= '0;
         cur_eof        <= 1'b0;
         addr_cnt       <= '0;
         bus.out_data   <= '0;
         bus.out_wren   <= 1'b0;
         bus.out_addr   <= '0;
         bus.frame_size <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.out_wren   <= issue;
         bus.frame_done <= (state == S_DONE);
         if (issue) begin
            bus.out_data <= shreg[IN_W-1 -: OUT_W];
            bus.out_addr <= addr_cnt;
            addr_cnt     <= addr_cnt + 1'b1;
            shreg        <= shreg << OUT_W;
            units_left   <= units_left - 1'b1;
         end
         if (load) begin
            shreg      <= h_padded;
            units_left <= h_units;
            cur_eof    <= h_eof;
         end
         if (state == S_DONE) begin
            bus.frame_size <= addr_cnt;
            addr_cnt       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_jpeg_bits_packer.sv
// Bench for jpeg_bits_packer: three instances (8-bit, 8-bit DEPTH=4, 16-bit units)
// driven by directed vectors, checked by a queue scoreboard and a monitor.
module tb_jpeg_bits_packer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] in_bits_a      [3];
   logic        in_valid_a     [3];
   logic        in_eof_valid_a [3];
   logic [4:0]  cnt_a          [3];
   logic        af_a           [3];
   logic [31:0] out_data_a     [3];
   logic        wren_a         [3];
   logic [23:0] out_addr_a     [3];
   logic [23:0] frame_size_a   [3];
   logic        frame_done_a   [3];
   logic        in_afull_a     [3];
   logic        overflow_a     [3];
   logic [1:0]  state_a        [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int OW = (g == 2) ? 16 : 8;
      localparam int DP = (g == 1) ? 4 : 16;
      jpeg_bits_packer_if #(.IN_W(32), .OUT_W(OW), .ADDR_W(24), .CNT_W(5)) bus ();
      assign bus.in_bits         = in_bits_a[g];
      assign bus.in_valid        = in_valid_a[g];
      assign bus.in_eof_valid    = in_eof_valid_a[g];
      assign bus.in_eof_cnt      = cnt_a[g];
      assign bus.out_almost_full = af_a[g];
      assign out_data_a[g]       = 32'(bus.out_data);
      assign wren_a[g]           = bus.out_wren;
      assign out_addr_a[g]       = bus.out_addr;
      assign frame_size_a[g]     = bus.frame_size;
      assign frame_done_a[g]     = bus.frame_done;
      assign in_afull_a[g]       = bus.in_afull;
      assign overflow_a[g]       = bus.overflow;
      jpeg_bits_packer #(.IN_W(32), .OUT_W(OW), .DEPTH(DP), .ADDR_W(24), .CNT_W(5)) dut (
         .clock     (clk),
         .reset     (rst),
         .bus       (bus.slave),
         .dbg_state (state_a[g])
      );
   end

   // scoreboard: {inst, addr, data} per unit, {inst, size} per frame
   logic [57:0] exp_q[$];
   logic [25:0] fs_q[$];
   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b1;

   task automatic chk(string name, logic [63:0] got, logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic monitor();
      logic [57:0] e;
      logic [25:0] f;
      forever begin
         @(negedge clk);
         if (mon_en) for (int i = 0; i < 3; i++) begin
            if (wren_a[i]) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unit_unexpected inst=%0d addr=%0d got=%h want=none",
                           i, out_addr_a[i], out_data_a[i]);
               end else begin
                  e = exp_q.pop_front();
                  chk("unit", 64'({2'(i), out_addr_a[i], out_data_a[i]}), 64'(e));
               end
            end
            if (frame_done_a[i]) begin
               if (fs_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL frame_unexpected inst=%0d got=%0d want=none",
                           i, frame_size_a[i]);
               end else begin
                  f = fs_q.pop_front();
                  chk("frame_size", 64'({2'(i), frame_size_a[i]}), 64'(f));
               end
            end
         end
      end
   endtask

   // called at a negedge; returns at the negedge after the push edge
   task automatic push(int i, bit eof, logic [4:0] cnt, logic [31:0] w);
      in_bits_a[i]      = w;
      cnt_a[i]          = cnt;
      in_valid_a[i]     = !eof;
      in_eof_valid_a[i] = eof;
      @(negedge clk);
      in_valid_a[i]     = 1'b0;
      in_eof_valid_a[i] = 1'b0;
   endtask

   task automatic exp_unit(int i, int addr, logic [31:0] d);
      exp_q.push_back({2'(i), 24'(addr), d});
   endtask

   task automatic exp_word(int i, int ow, int addr, logic [31:0] w);
      logic [31:0] u;
      for (int k = 0; k < 32 / ow; k++) begin
         u = (w >> (32 - ow * (k + 1))) & ((ow == 8) ? 32'h0000_00FF : 32'h0000_FFFF);
         exp_unit(i, addr + k, u);
      end
   endtask

   task automatic exp_frame(int i, int n);
      fs_q.push_back({2'(i), 24'(n)});
   endtask

   task automatic wait_drain(string name);
      int k = 0;
      while ((exp_q.size() != 0 || fs_q.size() != 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(exp_q.size() == 0 && fs_q.size() == 0), 64'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 3; i++) begin
         in_bits_a[i] = '0; in_valid_a[i] = 1'b0; in_eof_valid_a[i] = 1'b0;
         cnt_a[i] = '0; af_a[i] = 1'b0;
      end
      fork monitor(); join_none
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_wren",  64'(wren_a[i]), 64'd0);
         chk("rst_data",  64'(out_data_a[i]), 64'd0);
         chk("rst_addr",  64'(out_addr_a[i]), 64'd0);
         chk("rst_fsize", 64'(frame_size_a[i]), 64'd0);
         chk("rst_fdone", 64'(frame_done_a[i]), 64'd0);
         chk("rst_afull", 64'(in_afull_a[i]), 64'd0);
         chk("rst_ovf",   64'(overflow_a[i]), 64'd0);
         chk("rst_state", 64'(state_a[i]), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // T1: one word then an empty eof, with the two-edge latency checked
      exp_word(0, 8, 0, 32'h1234_5678);
      exp_frame(0, 4);
      push(0, 1'b0, 5'd0, 32'h1234_5678);
      chk("t1_lat_n", 64'(wren_a[0]), 64'd0);
      push(0, 1'b1, 5'd0, 32'h0);
      chk("t1_lat_n1", 64'(wren_a[0]), 64'd0);
      @(negedge clk);
      chk("t1_lat_n2", 64'(wren_a[0]), 64'd1);
      wait_drain("t1_drain");
      chk("t1_fsize", 64'(frame_size_a[0]), 64'd4);

      // T2: partial eof word, 12 valid bits, fill with ones
      exp_unit(0, 0, 32'hAB);
      exp_unit(0, 1, 32'hCF);
      exp_frame(0, 2);
      push(0, 1'b1, 5'd12, 32'hABC0_0000);
      wait_drain("t2_drain");
      chk("t2_fsize", 64'(frame_size_a[0]), 64'd2);

      // T3: sink stalls 10 cycles after the first byte
      exp_word(0, 8, 0, 32'h1122_3344);
      exp_word(0, 8, 4, 32'h5566_7788);
      exp_frame(0, 8);
      push(0, 1'b0, 5'd0, 32'h1122_3344);
      push(0, 1'b0, 5'd0, 32'h5566_7788);
      push(0, 1'b1, 5'd0, 32'h0);
      af_a[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t3_stall_wren", 64'(wren_a[0]), 64'd0);
      end
      af_a[0] = 1'b0;
      wait_drain("t3_drain");

      // T4: DEPTH=4 instance blocked, six pushes, last two dropped
      af_a[1] = 1'b1;
      exp_word(1, 8, 0,  32'hA0A1_A2A3);
      exp_word(1, 8, 4,  32'hB0B1_B2B3);
      exp_word(1, 8, 8,  32'hC0C1_C2C3);
      exp_word(1, 8, 12, 32'hD0D1_D2D3);
      push(1, 1'b0, 5'd0, 32'hA0A1_A2A3);
      chk("t4_afull_fill1", 64'(in_afull_a[1]), 64'd0);
      push(1, 1'b0, 5'd0, 32'hB0B1_B2B3);
      chk("t4_afull_fill2", 64'(in_afull_a[1]), 64'd1);
      push(1, 1'b0, 5'd0, 32'hC0C1_C2C3);
      push(1, 1'b0, 5'd0, 32'hD0D1_D2D3);
      chk("t4_ovf_before", 64'(overflow_a[1]), 64'd0);
      push(1, 1'b0, 5'd0, 32'hE0E1_E2E3);
      chk("t4_ovf_after", 64'(overflow_a[1]), 64'd1);
      push(1, 1'b0, 5'd0, 32'hF0F1_F2F3);
      repeat (3) @(negedge clk);
      chk("t4_no_wren_blocked", 64'(wren_a[1]), 64'd0);
      af_a[1] = 1'b0;
      wait_drain("t4_drain");
      exp_frame(1, 16);
      push(1, 1'b1, 5'd0, 32'h0);
      wait_drain("t4_frame");
      chk("t4_ovf_sticky", 64'(overflow_a[1]), 64'd1);

      // T5: back-to-back frames, address restarts, 20-bit tail
      exp_word(0, 8, 0, 32'h0102_0304);
      exp_word(0, 8, 4, 32'h0506_0708);
      exp_word(0, 8, 8, 32'h090A_0B0C);
      exp_frame(0, 12);
      exp_word(0, 8, 0, 32'hDEAD_BEEF);
      exp_unit(0, 4, 32'h9A);
      exp_unit(0, 5, 32'h5B);
      exp_unit(0, 6, 32'h3F);
      exp_frame(0, 7);
      push(0, 1'b0, 5'd0,  32'h0102_0304);
      push(0, 1'b0, 5'd0,  32'h0506_0708);
      push(0, 1'b0, 5'd0,  32'h090A_0B0C);
      push(0, 1'b1, 5'd0,  32'h0);
      push(0, 1'b0, 5'd0,  32'hDEAD_BEEF);
      push(0, 1'b1, 5'd20, 32'h9A5B_3000);
      wait_drain("t5_drain");
      chk("t5_fsize", 64'(frame_size_a[0]), 64'd7);

      // T6: 16-bit units, then reset in the middle of a word
      exp_unit(2, 0, 32'h1234);
      exp_unit(2, 1, 32'h5678);
      exp_frame(2, 2);
      push(2, 1'b0, 5'd0, 32'h1234_5678);
      push(2, 1'b1, 5'd0, 32'h0);
      wait_drain("t6_drain");
      chk("t6_fsize", 64'(frame_size_a[2]), 64'd2);

      mon_en = 1'b0;
      push(2, 1'b0, 5'd0, 32'hCAFE_F00D);
      push(2, 1'b0, 5'd0, 32'h0BAD_BEEF);
      seen = 0;
      for (int k = 0; k < 20 && seen == 0; k++) begin
         if (wren_a[2]) seen = 1;
         else @(negedge clk);
      end
      chk("t6_wren_seen", 64'(seen), 64'd1);
      chk("t6_midshift_state", 64'(state_a[2]), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_wren",  64'(wren_a[2]), 64'd0);
      chk("t6_rst_data",  64'(out_data_a[2]), 64'd0);
      chk("t6_rst_addr",  64'(out_addr_a[2]), 64'd0);
      chk("t6_rst_fsize", 64'(frame_size_a[2]), 64'd0);
      chk("t6_rst_state", 64'(state_a[2]), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      exp_unit(2, 0, 32'h1234);
      exp_unit(2, 1, 32'h5678);
      exp_frame(2, 2);
      push(2, 1'b0, 5'd0, 32'h1234_5678);
      push(2, 1'b1, 5'd0, 32'h0);
      wait_drain("t6_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
